// File: rtl/osc_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : osc_freq_meter
// Description : Ring-oscillator frequency meter. Counts synchronized rising
//               edges of osc_in over a gate window of GATE_CYCLES clk cycles
//               and reports the saturating edge count in the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module osc_freq_meter #(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int               GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             w_rise;
  logic [CNT_W-1:0] w_edge_next;
  logic             w_sat_next;

  // Two-flop synchronizer plus delay flop; runs in every state so the edge
  // detector is primed before a window opens.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= osc_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign w_rise = s2_q & ~s3_q;

  // Saturating edge counter step, including this cycle's rise.
  always_comb begin
    w_edge_next = edge_cnt_q;
    w_sat_next  = sat_q;
    if (w_rise) begin
      if (edge_cnt_q == CNT_MAX) begin
        w_sat_next = 1'b1;
      end else begin
        w_edge_next = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state logic: open a window on start, close it when the gate counter
  // reaches its last cycle, and either re-arm (continuous) or return to idle.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    valid_d    = 1'b0;
    count_d    = count_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          state_d    = MEASURE;
        end
      end
      MEASURE: begin
        if (gate_cnt_q == GATE_LAST) begin
          count_d    = w_edge_next;
          ovf_d      = w_sat_next;
          valid_d    = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          if (!continuous) begin
            state_d = IDLE;
          end
        end else begin
          gate_cnt_d = gate_cnt_q + GW'(1);
          edge_cnt_d = w_edge_next;
          sat_d      = w_sat_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == MEASURE);
  assign valid    = valid_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_osc_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_osc_freq_meter
// Description : Directed self-checking bench for osc_freq_meter. Two
//               instances: A (GATE=64, CNT_W=16) and B (GATE=128, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osc_freq_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        osc_a = 1'b0, osc_b = 1'b0;
  logic        hold_a = 1'b0, hold_b = 1'b0;
  int          half_a = 0, half_b = 0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        cont_a = 1'b0, cont_b = 1'b0;
  logic        busy_a, valid_a, ovf_a;
  logic        busy_b, valid_b, ovf_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;
  logic        sel_b = 1'b0;

  int total = 0;
  int bad   = 0;

  osc_freq_meter #(.GATE_CYCLES(64), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .osc_in(osc_a), .start(start_a),
    .continuous(cont_a), .busy(busy_a), .valid(valid_a),
    .count(count_a), .overflow(ovf_a)
  );

  osc_freq_meter #(.GATE_CYCLES(128), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .osc_in(osc_b), .start(start_b),
    .continuous(cont_b), .busy(busy_b), .valid(valid_b),
    .count(count_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  // Oscillator models: half period in time units, 0 means hold a level.
  always begin
    if (half_a == 0) begin osc_a = hold_a; #1; end
    else begin #(half_a) osc_a = ~osc_a; end
  end
  always begin
    if (half_b == 0) begin osc_b = hold_b; #1; end
    else begin #(half_b) osc_b = ~osc_b; end
  end

  wire        w_busy  = sel_b ? busy_b  : busy_a;
  wire        w_valid = sel_b ? valid_b : valid_a;
  wire        w_ovf   = sel_b ? ovf_b   : ovf_a;
  wire [15:0] w_count = sel_b ? {12'd0, count_b} : count_a;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel_b) start_b = v;
    else       start_a = v;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One start pulse, then watch for valid. exp_lat=0 means no valid expected.
  task automatic run(input bit b, input int exp_lat, input int exp_cnt,
                     input int exp_ov, input int start_at, input int rst_at,
                     input string tag);
    int n;
    bit seen;
    int lat;
    n = 0; seen = 1'b0; lat = 0;
    sel_b = b;
    @(negedge clk);
    set_start(1'b1);
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1 || n == start_at + 1) set_start(1'b0);
      if (n == start_at) set_start(1'b1);
      if (n == rst_at) rst = 1'b1;
      if (n == rst_at + 1) begin
        rst = 1'b0;
        chk({tag, "_busy0"},  int'(w_busy),  0);
        chk({tag, "_valid0"}, int'(w_valid), 0);
        chk({tag, "_count0"}, int'(w_count), 0);
        chk({tag, "_ovf0"},   int'(w_ovf),   0);
      end
      if (w_valid) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    if (exp_lat > 0) begin
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_busy_at_valid"}, int'(w_busy), 0);
      chk({tag, "_count"}, int'(w_count), exp_cnt);
      chk({tag, "_overflow"}, int'(w_ovf), exp_ov);
      @(negedge clk);
      chk({tag, "_pulse_width"}, int'(w_valid), 0);
    end else begin
      chk({tag, "_no_valid"}, int'(seen), 0);
    end
  endtask

  initial begin
    int nv;
    int vt [4];
    int vc [4];
    bit drop;
    int extra;
    int busy_last;

    rst = 1'b1;
    wait_cycles(3);
    chk("reset_busy",  int'(busy_a),  0);
    chk("reset_valid", int'(valid_a), 0);
    chk("reset_count", int'(count_a), 0);
    chk("reset_ovf",   int'(ovf_a),   0);
    chk("reset_b_busy", int'(busy_b), 0);
    rst = 1'b0;

    // Period-8 square wave, single window.
    half_a = 40;
    wait_cycles(20);
    run(1'b0, 65, 8, 0, -1, -1, "basic");

    // Constant inputs.
    half_a = 0; hold_a = 1'b0;
    wait_cycles(20);
    run(1'b0, 65, 0, 0, -1, -1, "hold0");
    hold_a = 1'b1;
    wait_cycles(20);
    run(1'b0, 65, 0, 0, -1, -1, "hold1");

    // Saturation on the narrow counter, then a run that fits.
    half_b = 20;
    wait_cycles(20);
    run(1'b1, 129, 15, 1, -1, -1, "sat");
    half_b = 80;
    wait_cycles(40);
    run(1'b1, 129, 8, 0, -1, -1, "nosat");

    // Continuous mode: four windows, continuous dropped during the fourth.
    sel_b = 1'b0;
    half_a = 40;
    wait_cycles(20);
    nv = 0; drop = 1'b0; extra = 0; busy_last = 1;
    for (int i = 0; i < 4; i++) begin vt[i] = 0; vc[i] = -1; end
    cont_a = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) start_a = 1'b0;
      if (valid_a) begin
        if (nv < 4) begin
          vt[nv] = n;
          vc[nv] = int'(count_a);
          if (nv == 3) busy_last = int'(busy_a);
          nv++;
          if (nv == 3) cont_a = 1'b0;
        end else begin
          extra++;
        end
      end else if (nv < 4 && !busy_a) begin
        drop = 1'b1;
      end
    end
    chk("cont_nvalid", nv, 4);
    chk("cont_first_lat", vt[0], 65);
    chk("cont_gap1", vt[1] - vt[0], 64);
    chk("cont_gap2", vt[2] - vt[1], 64);
    chk("cont_gap3", vt[3] - vt[2], 64);
    for (int i = 0; i < 4; i++) chk($sformatf("cont_count%0d", i), vc[i], 8);
    chk("cont_busy_drop", int'(drop), 0);
    chk("cont_busy_after_stop", busy_last, 0);
    chk("cont_extra_valid", extra, 0);

    // Start pulsed again mid-window is ignored.
    run(1'b0, 65, 8, 0, 20, -1, "restart_ignored");

    // Reset at cycle 30 aborts the window, then a clean run.
    run(1'b0, 0, 0, 0, -1, 30, "rst_abort");
    wait_cycles(20);
    run(1'b0, 65, 8, 0, -1, -1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
